// File: rtl/poly_eval_pkg.sv
// Shared definitions for the polynomial evaluator: op encoding, FSM states,
// default parameters and the accumulator sizing rule.
package poly_eval_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_NCOEF = 5;
    localparam int DEF_ARG_W = 3;
    localparam int DEF_OUT_W = 10;

    localparam logic OP_POLY  = 1'b0;
    localparam logic OP_DERIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        COMMIT
    } fsmState_t;

    // Every Horner partial is bounded by NCOEF * |argMin|^NCOEF; the extra
    // clog2 terms also cover the ARG_W = 1 case, where the bound is NCOEF^2.
    function automatic int accWidth(input int nCoef, input int argW);
        return (argW - 1) * nCoef + 2 * $clog2(nCoef + 1) + 2;
    endfunction

endpackage

// File: rtl/poly_eval_ram_if.sv
// Write-request / read-port bundle of poly_eval_ram. The master side issues
// evaluation requests and reads; the slave side is the evaluator itself.
interface poly_eval_ram_if
    import poly_eval_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int NCOEF = DEF_NCOEF,
    parameter int ARG_W = DEF_ARG_W,
    parameter int OUT_W = DEF_OUT_W
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_req;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [NCOEF-1:0]  wr_coef;
    logic              wr_op;
    logic [ARG_W-1:0]  wr_arg;
    logic              wr_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [OUT_W-1:0]  rd_data;
    logic              rd_valid;

    modport master (
        output wr_req, wr_addr, wr_coef, wr_op, wr_arg, rd_en, rd_addr,
        input  wr_ready, wr_done, rd_data, rd_valid
    );

    modport slave (
        input  wr_req, wr_addr, wr_coef, wr_op, wr_arg, rd_en, rd_addr,
        output wr_ready, wr_done, rd_data, rd_valid
    );

endinterface

// File: rtl/horner_step.sv
// One combinational Horner step: result = acc * arg + k, all in the
// accumulator width (which is sized so the product never overflows).
module horner_step
    import poly_eval_pkg::*;
#(
    parameter int ACC_W = accWidth(DEF_NCOEF, DEF_ARG_W),
    parameter int ARG_W = DEF_ARG_W
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [ARG_W-1:0] arg,
    input  logic signed [ACC_W-1:0] k,
    output logic signed [ACC_W-1:0] result
);
    logic signed [ACC_W-1:0] argExt;

    assign argExt = ACC_W'(arg);
    assign result = acc * argExt + k;

endmodule

// File: rtl/poly_eval_ram.sv
// Evaluates p(x) or p'(x) with 1-bit coefficients by Horner's rule and stores
// the sign-magnitude result in a small RAM. POLY_EVAL_SAT_EN selects
// saturation plus a sticky ovf output instead of magnitude truncation.
module poly_eval_ram
    import poly_eval_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int NCOEF = DEF_NCOEF,
    parameter int ARG_W = DEF_ARG_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic CLK,
    input  logic RST_N,
`ifdef POLY_EVAL_SAT_EN
    output logic ovf,
`endif
    poly_eval_ram_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ACC_W  = accWidth(NCOEF, ARG_W);
    localparam int CNT_W  = $clog2(NCOEF);
    localparam int MAG_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    fsmState_t state, stateNext;

    logic [ADDR_W-1:0]       addrQ;
    logic [NCOEF-1:0]        coefQ;
    logic                    opQ;
    logic signed [ARG_W-1:0] argQ;
    logic signed [ACC_W-1:0] acc, accNext, termK;
    logic [CNT_W-1:0]        idx;
    logic                    lastStep, accept, wrDone;
    logic                    wrInRange, rdInRange;
    logic [MAG_W-1:0]        magWide;
    logic [OUT_W-1:0]        commitWord;
    logic [OUT_W-1:0]        rdData;
    logic                    rdValid;
    logic [OUT_W-1:0]        mem [DEPTH];

    assign accept    = bus.wr_req && (state == IDLE);
    assign lastStep  = (opQ == OP_DERIV) ? (idx == CNT_W'(1)) : (idx == '0);
    assign wrInRange = {1'b0, addrQ} < (ADDR_W + 1)'(DEPTH);
    assign rdInRange = {1'b0, bus.rd_addr} < (ADDR_W + 1)'(DEPTH);

    // NOTE: every variable gets a default before the case/if so that no path
    // leaves it unassigned and a latch is never inferred.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (bus.wr_req) stateNext = EVAL;
            EVAL:    if (lastStep) stateNext = COMMIT;
            COMMIT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= stateNext;
    end

    // Horner term for the current index: c[i] for p(x), i*c[i] for p'(x).
    always_comb begin
        termK = '0;
        if (coefQ[idx]) termK = (opQ == OP_DERIV) ? ACC_W'(idx) : ACC_W'(1);
    end

    horner_step #(
        .ACC_W (ACC_W),
        .ARG_W (ARG_W)
    ) u_horner_step (
        .acc    (acc),
        .arg    (argQ),
        .k      (termK),
        .result (accNext)
    );

    // NOTE: sequential state uses non-blocking assignments, so every block
    // clocked on the same edge sees the pre-edge values of the others.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addrQ  <= '0;
            coefQ  <= '0;
            opQ    <= OP_POLY;
            argQ   <= '0;
            acc    <= '0;
            idx    <= '0;
            wrDone <= 1'b0;
        end else begin
            wrDone <= (state == COMMIT);
            if (accept) begin
                addrQ <= bus.wr_addr;
                coefQ <= bus.wr_coef;
                opQ   <= bus.wr_op;
                argQ  <= bus.wr_arg;
                acc   <= '0;
                idx   <= CNT_W'(NCOEF - 1);
            end else if (state == EVAL) begin
                acc <= accNext;
                if (!lastStep) idx <= idx - 1'b1;
            end
        end
    end

    // Sign-magnitude conversion; a zero result naturally carries sign 0.
    always_comb begin
        magWide = acc[ACC_W-1] ? MAG_W'(-acc) : MAG_W'(acc);
    end

`ifdef POLY_EVAL_SAT_EN
    logic commitOvf;
    logic ovfQ;

    assign commitOvf  = |magWide[MAG_W-1:OUT_W-1];
    assign commitWord = {acc[ACC_W-1],
                         commitOvf ? {(OUT_W - 1){1'b1}} : magWide[OUT_W-2:0]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                           ovfQ <= 1'b0;
        else if (state == COMMIT && commitOvf) ovfQ <= 1'b1;
    end

    assign ovf = ovfQ;
`else
    assign commitWord = {acc[ACC_W-1], magWide[OUT_W-2:0]};
`endif

    // NOTE: the storage is a register array with async reset, because reset
    // must clear every word; it is not meant to map onto a RAM macro.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == COMMIT && wrInRange) begin
            mem[addrQ] <= commitWord;
        end
    end

    // A read of the word being committed on the same edge returns the old word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= bus.rd_en;
            if (bus.rd_en) rdData <= rdInRange ? mem[bus.rd_addr] : '0;
        end
    end

    assign bus.wr_ready = (state == IDLE);
    assign bus.wr_done  = wrDone;
    assign bus.rd_data  = rdData;
    assign bus.rd_valid = rdValid;

endmodule

// File: tb/tb_poly_eval_ram.sv
// Self-checking bench for poly_eval_ram: a latency/arithmetic reference model
// compared every cycle, directed cases with literal results, then random traffic.
module tb_poly_eval_ram;
    import poly_eval_pkg::*;

    localparam int DEPTH  = 12;
    localparam int NCOEF  = DEF_NCOEF;
    localparam int ARG_W  = DEF_ARG_W;
    localparam int OUT_W  = 8;
    localparam int ADDR_W = $clog2(DEPTH);
`ifdef POLY_EVAL_SAT_EN
    localparam logic [OUT_W-1:0] EXP_205 = 8'h7F;
`else
    localparam logic [OUT_W-1:0] EXP_205 = 8'h4D;
`endif

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    poly_eval_ram_if #(.DEPTH(DEPTH), .NCOEF(NCOEF), .ARG_W(ARG_W), .OUT_W(OUT_W)) bus ();

`ifdef POLY_EVAL_SAT_EN
    logic ovf;
`endif

    poly_eval_ram #(.DEPTH(DEPTH), .NCOEF(NCOEF), .ARG_W(ARG_W), .OUT_W(OUT_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
`ifdef POLY_EVAL_SAT_EN
        .ovf   (ovf),
`endif
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit checkEn    = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [OUT_W-1:0]  mdlMem [DEPTH];
    int                countdown;
    logic [ADDR_W-1:0] pendAddr;
    logic [OUT_W-1:0]  pendWord;
    bit                pendOvf, mdlOvf;
    bit                expReady, expDone, expRdValid;
    logic [OUT_W-1:0]  expRdData;

    function automatic int polyValue(input logic [NCOEF-1:0] coef, input logic op, input int x);
        int sum;
        int pw;
        sum = 0;
        for (int i = 0; i < NCOEF; i++) begin
            if (coef[i] && op == OP_POLY) begin
                pw = 1;
                for (int j = 0; j < i; j++) pw *= x;
                sum += pw;
            end else if (coef[i] && i > 0) begin
                pw = 1;
                for (int j = 0; j < i - 1; j++) pw *= x;
                sum += i * pw;
            end
        end
        return sum;
    endfunction

    function automatic logic [OUT_W-1:0] toStored(input int v, output bit ov);
        int mag;
        int maxMag;
        mag    = (v < 0) ? -v : v;
        maxMag = (1 << (OUT_W - 1)) - 1;
        ov     = mag > maxMag;
`ifdef POLY_EVAL_SAT_EN
        if (ov) mag = maxMag;
`else
        mag = mag % (maxMag + 1);
`endif
        return {(v < 0) ? 1'b1 : 1'b0, mag[OUT_W-2:0]};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mdlMem[i] = '0;
        countdown  = 0;
        mdlOvf     = 1'b0;
        expReady   = 1'b1;
        expDone    = 1'b0;
        expRdValid = 1'b0;
        expRdData  = '0;
    endtask

    task automatic modelStep();
        if (bus.rd_en) begin
            expRdValid = 1'b1;
            expRdData  = (int'(bus.rd_addr) < DEPTH) ? mdlMem[bus.rd_addr] : '0;
        end else begin
            expRdValid = 1'b0;
        end
        expDone = 1'b0;
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                if (int'(pendAddr) < DEPTH) mdlMem[pendAddr] = pendWord;
                mdlOvf  = mdlOvf | pendOvf;
                expDone = 1'b1;
            end
        end else if (bus.wr_req) begin
            pendAddr  = bus.wr_addr;
            pendWord  = toStored(polyValue(bus.wr_coef, bus.wr_op, int'($signed(bus.wr_arg))), pendOvf);
            countdown = (bus.wr_op == OP_DERIV) ? NCOEF : NCOEF + 1;
        end
        expReady = (countdown == 0);
    endtask

    initial forever begin
        @(posedge CLK);
        if (RST_N) modelStep();
    end

    initial forever begin
        @(negedge RST_N);
        modelReset();
    end

    initial forever begin
        @(negedge CLK);
        if (checkEn) begin
            check("wr_ready", bus.wr_ready, expReady);
            check("wr_done",  bus.wr_done,  expDone);
            check("rd_valid", bus.rd_valid, expRdValid);
            check("rd_data",  bus.rd_data,  expRdData);
`ifdef POLY_EVAL_SAT_EN
            check("ovf", ovf, mdlOvf);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic writeOp(input logic [ADDR_W-1:0] a, input logic [NCOEF-1:0] c, input logic op,
                           input int x, input bit poke, output int lat);
        int waitCnt;
        waitCnt = 0;
        @(negedge CLK);
        while (!bus.wr_ready && waitCnt < 50) begin
            @(negedge CLK);
            waitCnt++;
        end
        bus.wr_req  = 1'b1;
        bus.wr_addr = a;
        bus.wr_coef = c;
        bus.wr_op   = op;
        bus.wr_arg  = ARG_W'(x);
        @(posedge CLK);
        @(negedge CLK);
        if (poke) begin
            bus.wr_addr = ADDR_W'(9);
            bus.wr_coef = NCOEF'(1);
            bus.wr_op   = OP_POLY;
            bus.wr_arg  = '0;
        end else begin
            bus.wr_req = 1'b0;
        end
        lat = 0;
        repeat (3 * NCOEF) begin
            @(posedge CLK);
            lat++;
            #1;
            bus.wr_req = 1'b0;
            if (bus.wr_done) break;
            check("busy_not_ready", bus.wr_ready, 1'b0);
        end
        if (!bus.wr_done) begin
            check("wr_done_timeout", 1'b0, 1'b1);
            lat = -1;
        end
    endtask

    task automatic readOp(input logic [ADDR_W-1:0] a, output logic [OUT_W-1:0] d);
        @(negedge CLK);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        @(posedge CLK);
        #1 d = bus.rd_data;
        @(negedge CLK);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        int               lat;
        int               doneSeen;
        bit               ov;
        logic [OUT_W-1:0] d;

        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_coef = '0;
        bus.wr_op   = OP_POLY;
        bus.wr_arg  = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        modelReset();
        repeat (3) @(negedge CLK);
        check("reset_wr_ready", bus.wr_ready, 1'b1);
        check("reset_rd_data",  bus.rd_data,  '0);
        #2 RST_N = 1'b1;
        checkEn = 1'b1;

        // Hand-computed values that pin the model.
        check("model_deriv_m1", polyValue(5'b01011, OP_DERIV, -1), 4);
        check("model_poly_m2",  polyValue(5'b01011, OP_POLY, -2), -9);
        check("model_poly_m4",  polyValue(5'b11111, OP_POLY, -4), 205);
        check("model_store_m9", toStored(-9, ov), 8'h89);

        writeOp(4, 5'b01011, OP_DERIV, -1, 1'b0, lat);
        check("lat_deriv", lat, NCOEF);
        readOp(4, d);
        check("rd_addr4", d, 8'h04);

        writeOp(2, 5'b01011, OP_POLY, -2, 1'b0, lat);
        check("lat_poly", lat, NCOEF + 1);
        readOp(2, d);
        check("rd_addr2", d, 8'h89);

        writeOp(0, 5'b11111, OP_POLY, -4, 1'b1, lat);
        check("lat_poly_poked", lat, NCOEF + 1);
        readOp(0, d);
        check("rd_addr0", d, EXP_205);
        readOp(9, d);
        check("rd_addr9_untouched", d, 8'h00);

        writeOp(5, 5'b00000, OP_POLY, 3, 1'b0, lat);
        readOp(5, d);
        check("rd_zero_sign", d, 8'h00);

        writeOp(13, 5'b00011, OP_POLY, 1, 1'b0, lat);
        check("lat_out_of_range", lat, NCOEF + 1);
        readOp(13, d);
        check("rd_out_of_range", d, 8'h00);

        // Read-before-write on the committing word.
        writeOp(3, 5'b01011, OP_DERIV, -1, 1'b0, lat);
        @(negedge CLK);
        bus.wr_req  = 1'b1;
        bus.wr_addr = 3;
        bus.wr_coef = 5'b01011;
        bus.wr_op   = OP_POLY;
        bus.wr_arg  = ARG_W'(-2);
        @(posedge CLK);
        @(negedge CLK);
        bus.wr_req = 1'b0;
        repeat (NCOEF) @(negedge CLK);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 3;
        @(posedge CLK);
        #1;
        check("commit_cycle_done", bus.wr_done, 1'b1);
        check("commit_cycle_old",  bus.rd_data, 8'h04);
        @(posedge CLK);
        #1 check("after_commit_new", bus.rd_data, 8'h89);
        @(negedge CLK);
        bus.rd_en = 1'b0;

        // Reset in the middle of EVAL aborts the write.
        @(negedge CLK);
        bus.wr_req  = 1'b1;
        bus.wr_addr = 7;
        bus.wr_coef = 5'b10101;
        bus.wr_op   = OP_POLY;
        bus.wr_arg  = ARG_W'(2);
        @(posedge CLK);
        @(negedge CLK);
        bus.wr_req = 1'b0;
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("abort_wr_ready", bus.wr_ready, 1'b1);
        check("abort_wr_done",  bus.wr_done,  1'b0);
        check("abort_rd_data",  bus.rd_data,  '0);
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b1;
        doneSeen = 0;
        repeat (2 * NCOEF) begin
            @(posedge CLK);
            #1 if (bus.wr_done) doneSeen++;
        end
        check("abort_no_done", doneSeen, 0);
        readOp(7, d);
        check("abort_rd_addr7", d, 8'h00);
        readOp(4, d);
        check("reset_cleared_addr4", d, 8'h00);

        // Random traffic checked by the compare process.
        repeat (600) begin
            @(negedge CLK);
            bus.wr_req  = ($urandom_range(0, 3) == 0);
            bus.wr_addr = ADDR_W'($urandom_range(0, 15));
            bus.wr_coef = NCOEF'($urandom);
            bus.wr_op   = 1'($urandom_range(0, 1));
            bus.wr_arg  = ARG_W'($urandom);
            bus.rd_en   = 1'($urandom_range(0, 1));
            bus.rd_addr = ADDR_W'($urandom_range(0, 15));
        end
        @(negedge CLK);
        bus.wr_req = 1'b0;
        bus.rd_en  = 1'b0;
        repeat (2 * NCOEF) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/poly_eval_ram.md
POLY_EVAL_RAM -- requirements
Module: poly_eval_ram

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of result words stored.
REQ-002 The block SHALL have parameter NCOEF, default 5, meaning the number of 1-bit coefficients c[NCOEF-1:0], with p(x)=sum c[i]*x^i.
REQ-003 The block SHALL have parameter ARG_W, default 3, meaning the two's-complement argument width (default range -4..3).
REQ-004 The block SHALL have parameter OUT_W, default 10, meaning the stored word width: bit OUT_W-1 is the sign, bits OUT_W-2:0 are the magnitude.
REQ-005 The block SHALL have these ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- wr_req  in  1  request to evaluate and store; accepted when wr_req && wr_ready.
- wr_ready  out  1  high when idle.
- wr_addr  in  clog2(DEPTH)  destination word.
- wr_coef  in  NCOEF  coefficient bits.
- wr_op  in  1  0 = p(x), 1 = p'(x).
- wr_arg  in  ARG_W  signed evaluation argument.
- wr_done  out  1  one-cycle pulse on commit.
- rd_en  in  1  read request.
- rd_addr  in  clog2(DEPTH)  read word.
- rd_data  out  OUT_W  registered read data.
- rd_valid  out  1  one-cycle pulse, rd_data valid.

Function
REQ-006 FSM states SHALL be IDLE, EVAL and COMMIT; only IDLE asserts wr_ready.
REQ-007 On acceptance, addr, coef, op and arg SHALL be latched, the accumulator SHALL be cleared and the FSM SHALL enter EVAL.
REQ-008 EVAL SHALL perform one Horner step per cycle, acc = acc*arg + k, from the highest term down.
- p(x): k = c[i], i = NCOEF-1..0, NCOEF steps.
- p'(x): k = i*c[i], i = NCOEF-1..1, NCOEF-1 steps.
REQ-009 The accumulator SHALL be signed and wide enough that no intermediate value overflows for any legal parameter set.
REQ-010 COMMIT SHALL write the sign-magnitude conversion of acc to mem[addr], pulse wr_done for one cycle and return to IDLE.
REQ-011 Latency SHALL be fixed: wr_done rises NCOEF+1 (p) or NCOEF (p') cycles after the accepting edge.
REQ-012 Result zero SHALL be stored with sign 0.
REQ-013 wr_req while busy SHALL be ignored, with no queueing.
REQ-014 Inputs SHALL be sampled only at acceptance; later changes SHALL have no effect on the operation in flight.
REQ-015 Reads SHALL be independent of the FSM: rd_en at edge N gives rd_data = mem[rd_addr] and rd_valid = 1 after edge N.
REQ-016 A read of the COMMIT address in the COMMIT cycle SHALL return the old word (read-before-write).
REQ-017 rd_data SHALL hold its last value while rd_en = 0.
REQ-018 Addresses of DEPTH or above SHALL be ignored on writes (FSM still completes, wr_done still pulses) and SHALL return 0 on reads.

Reset
REQ-019 RST_N low SHALL force, asynchronously: FSM to IDLE, wr_ready = 1, wr_done = 0, rd_valid = 0, rd_data = 0, every mem word = 0.
REQ-020 Reset during EVAL or COMMIT SHALL abort the operation without producing a wr_done pulse.

Configuration
REQ-021 With POLY_EVAL_SAT_EN defined:
- a magnitude exceeding 2^(OUT_W-1)-1 SHALL saturate to all ones, keeping the sign;
- output port ovf (1 bit) SHALL be sticky high from that commit until reset.
REQ-022 Without POLY_EVAL_SAT_EN, the magnitude SHALL be truncated to its low OUT_W-1 bits, and port ovf SHALL not exist.

Structure
REQ-023 Package poly_eval_pkg SHALL hold:
- the op encoding constants OP_POLY and OP_DERIV;
- the FSM state typedef;
- the default parameter values.
REQ-024 Horner datapath: sub-module horner_step SHALL be combinational, computing acc*arg + k. The FSM, counter and memory SHALL stay in poly_eval_ram.

Verification
REQ-025 Write addr 4, coef 01011, op p', arg -1 -> wr_done exactly 5 cycles after accept; read addr 4 -> 0_000000100 (+4).
REQ-026 Write addr 2, coef 01011, op p, arg -2 -> wr_done after 6 cycles; read -> 1_000001001 (-9).
REQ-027 Write addr 0, coef 11111, op p, arg -4 -> read 0_011001101 (+205); wr_req pulsed during EVAL -> ignored, wr_ready = 0 throughout.
REQ-028 OUT_W = 8 with POLY_EVAL_SAT_EN; coef 11111, op p, arg -4 -> stored 0_1111111 and ovf = 1; without the macro -> stored 0_1001101.
REQ-029 Reset asserted mid-EVAL on addr 7 -> immediate wr_ready = 1, no wr_done pulse, read addr 7 -> 0.
REQ-030 Read addr 3 in the COMMIT cycle of a write to addr 3 -> old value returned; next read -> new value.
